rob_commit_unit: RTL and testbench

- Reorder buffer sitting directly downstream of the rename stage.
- Accepts each renamed instruction with its displaced physical register and tracks completion.
- Retires instructions in program order, one per cycle.
- Drives the commit/free-list return interface (p_commit, prev_prf_idx, prev_prf_idx_valid) back to rename; squashes wrong-path entries on a branch mispredict using a single outstanding branch tag.

---
 rtl/rob_commit_unit.sv | 139 +++++++++++++
 tb/tb_rob_commit_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order reorder buffer with single-branch squash and free-list return to rename
module rob_commit_unit #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [24:0]      rinstr_i,
    input  logic [5:0]       prev_prf_idx_i,
    input  logic             prev_prf_idx_valid_i,
    input  logic             is_branch_i,
    input  logic             alloc_stall_i,
    output logic [TAG_W-1:0] alloc_tag_o,
    output logic             rob_full_o,
    output logic             rob_empty_o,
    input  logic             cmpl0_valid_i,
    input  logic             cmpl1_valid_i,
    input  logic [TAG_W-1:0] cmpl0_tag_i,
    input  logic [TAG_W-1:0] cmpl1_tag_i,
    input  logic [1:0]       br_result_i,
    output logic [7:0]       p_commit_o,
    output logic [5:0]       prev_prf_idx_o,
    output logic             prev_prf_idx_valid_o,
    output logic             branch_pending_o
);
    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic       ready;
    } p_reg_t;
    typedef struct packed {
        logic   valid;
        p_reg_t rd;
        p_reg_t rs1;
        p_reg_t rs2;
    } rinstr_t;

    rinstr_t          rin;
    logic             unused_rin;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [DEPTH-1:0] rdv_q, rdv_d, pv_q, pv_d, br_q, br_d;
    logic [5:0]       rd_idx_q [DEPTH];
    logic [5:0]       rd_idx_d [DEPTH];
    logic [5:0]       prev_idx_q [DEPTH];
    logic [5:0]       prev_idx_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, br_tag_q, br_tag_d, flush_cnt;
    logic [TAG_W:0]   count_q, count_d;
    logic             br_pending_q, br_pending_d;
    logic             commit, alloc, resolve, mispredict;

    assign rin        = rinstr_i;
    assign unused_rin = ^{rin.rd.ready, rin.rs1, rin.rs2};
    assign rob_full_o  = count_q == (TAG_W+1)'(DEPTH);
    assign rob_empty_o = count_q == '0;
    assign alloc_tag_o = tail_q;
    assign branch_pending_o = br_pending_q;
    assign resolve    = br_result_i[1] && br_pending_q;
    assign mispredict = resolve && !br_result_i[0];
    assign commit = rst_ni && valid_q[head_q] && done_q[head_q];
    assign alloc  = rin.valid && !alloc_stall_i && !rob_full_o && !mispredict;
    assign p_commit_o = {commit, commit && rdv_q[head_q] ? rd_idx_q[head_q] : 6'd0, commit};
    assign prev_prf_idx_o = commit ? prev_idx_q[head_q] : 6'd0;
    assign prev_prf_idx_valid_o = commit && rdv_q[head_q] && pv_q[head_q] && prev_idx_q[head_q] != 6'd0;

    always_comb begin
        valid_d      = valid_q;
        done_d       = done_q;
        rdv_d        = rdv_q;
        pv_d         = pv_q;
        br_d         = br_q;
        rd_idx_d     = rd_idx_q;
        prev_idx_d   = prev_idx_q;
        head_d       = head_q + TAG_W'(commit);
        tail_d       = tail_q;
        count_d      = count_q - (TAG_W+1)'(commit);
        br_pending_d = br_pending_q && !resolve;
        br_tag_d     = br_tag_q;
        flush_cnt    = br_tag_q - head_d + TAG_W'(1);
        if (cmpl0_valid_i && valid_q[cmpl0_tag_i] && !br_q[cmpl0_tag_i])
            done_d[cmpl0_tag_i] = 1'b1;
        if (cmpl1_valid_i && valid_q[cmpl1_tag_i] && !br_q[cmpl1_tag_i])
            done_d[cmpl1_tag_i] = 1'b1;
        if (resolve)
            done_d[br_tag_q] = 1'b1;
        if (commit)
            valid_d[head_q] = 1'b0;
        // an entry is younger than the branch when it sits further from head
        if (mispredict) begin
            for (int i = 0; i < DEPTH; i++)
                if (TAG_W'(i) - head_q > br_tag_q - head_q)
                    valid_d[i] = 1'b0;
            tail_d  = br_tag_q + TAG_W'(1);
            count_d = flush_cnt == '0 ? (TAG_W+1)'(DEPTH) : {1'b0, flush_cnt};
        end
        if (alloc) begin
            valid_d[tail_q]    = 1'b1;
            done_d[tail_q]     = 1'b0;
            rdv_d[tail_q]      = rin.rd.valid;
            rd_idx_d[tail_q]   = rin.rd.idx;
            pv_d[tail_q]       = prev_prf_idx_valid_i;
            prev_idx_d[tail_q] = prev_prf_idx_i;
            br_d[tail_q]       = is_branch_i;
            tail_d             = tail_q + TAG_W'(1);
            count_d            = count_d + (TAG_W+1)'(1);
            if (is_branch_i && (!br_pending_q || resolve)) begin
                br_pending_d = 1'b1;
                br_tag_d     = tail_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            br_pending_q <= 1'b0;
            br_tag_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            br_pending_q <= br_pending_d;
            br_tag_q     <= br_tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rdv_q      <= rdv_d;
        pv_q       <= pv_d;
        br_q       <= br_d;
        rd_idx_q   <= rd_idx_d;
        prev_idx_q <= prev_idx_d;
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: directed stimulus with a commit scoreboard checked by an independent monitor
module tb_rob_commit_unit;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic [24:0] rinstr_i;
    logic [5:0]  prev_prf_idx_i;
    logic        prev_prf_idx_valid_i;
    logic        is_branch_i;
    logic        alloc_stall_i;
    logic [3:0]  alloc_tag_o;
    logic        rob_full_o;
    logic        rob_empty_o;
    logic        cmpl0_valid_i;
    logic        cmpl1_valid_i;
    logic [3:0]  cmpl0_tag_i;
    logic [3:0]  cmpl1_tag_i;
    logic [1:0]  br_result_i;
    logic [7:0]  p_commit_o;
    logic [5:0]  prev_prf_idx_o;
    logic        prev_prf_idx_valid_o;
    logic        branch_pending_o;

    typedef struct packed {
        logic [5:0] idx;
        logic [5:0] prev;
        logic       pv;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rob_commit_unit #(.DEPTH(16)) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .rinstr_i(rinstr_i),
        .prev_prf_idx_i(prev_prf_idx_i),
        .prev_prf_idx_valid_i(prev_prf_idx_valid_i),
        .is_branch_i(is_branch_i),
        .alloc_stall_i(alloc_stall_i),
        .alloc_tag_o(alloc_tag_o),
        .rob_full_o(rob_full_o),
        .rob_empty_o(rob_empty_o),
        .cmpl0_valid_i(cmpl0_valid_i),
        .cmpl1_valid_i(cmpl1_valid_i),
        .cmpl0_tag_i(cmpl0_tag_i),
        .cmpl1_tag_i(cmpl1_tag_i),
        .br_result_i(br_result_i),
        .p_commit_o(p_commit_o),
        .prev_prf_idx_o(prev_prf_idx_o),
        .prev_prf_idx_valid_o(prev_prf_idx_valid_o),
        .branch_pending_o(branch_pending_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [5:0] rd, input logic rdv, input logic [5:0] prev, input logic pv,
                         input logic br, input logic [3:0] exp_tag, input bit push);
        rinstr_i             = {1'b1, rdv, rd, 1'b0, 16'h0000};
        prev_prf_idx_i       = prev;
        prev_prf_idx_valid_i = pv;
        is_branch_i          = br;
        check("alloc_tag", 32'(alloc_tag_o), 32'(exp_tag));
        if (push)
            sb.push_back('{rdv ? rd : 6'd0, prev, rdv && pv && prev != 6'd0});
        tick();
        rinstr_i    = '0;
        is_branch_i = 1'b0;
    endtask

    task automatic cmpl(input logic [3:0] tag);
        cmpl0_valid_i = 1'b1;
        cmpl0_tag_i   = tag;
        tick();
        cmpl0_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (p_commit_o[7]) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL commit_unexpected: got idx %0d, expected no commit", p_commit_o[6:1]);
            end else begin
                e = sb.pop_front();
                if (p_commit_o[6:0] !== {e.idx, 1'b1} || prev_prf_idx_valid_o !== e.pv ||
                    (e.pv && prev_prf_idx_o !== e.prev)) begin
                    n_err++;
                    $display("FAIL commit: got idx %0d ready %0b prev %0d pv %0b, expected idx %0d ready 1 prev %0d pv %0b",
                             p_commit_o[6:1], p_commit_o[0], prev_prf_idx_o, prev_prf_idx_valid_o, e.idx, e.prev, e.pv);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        rinstr_i = '0;
        prev_prf_idx_i = '0;
        prev_prf_idx_valid_i = 1'b0;
        is_branch_i = 1'b0;
        alloc_stall_i = 1'b0;
        cmpl0_valid_i = 1'b0;
        cmpl1_valid_i = 1'b0;
        cmpl0_tag_i = '0;
        cmpl1_tag_i = '0;
        br_result_i = '0;
        repeat (2) tick();
        check("rst_p_commit", 32'(p_commit_o), 0);
        check("rst_prev_idx", 32'(prev_prf_idx_o), 0);
        check("rst_prev_valid", 32'(prev_prf_idx_valid_o), 0);
        check("rst_empty", 32'(rob_empty_o), 1);
        check("rst_full", 32'(rob_full_o), 0);
        check("rst_br_pending", 32'(branch_pending_o), 0);
        check("rst_alloc_tag", 32'(alloc_tag_o), 0);
        rst_ni = 1'b1;

        for (int i = 0; i < 16; i++)
            alloc(6'(i + 1), 1'b1, 6'(i), 1'b1, 1'b0, 4'(i), 1'b0);
        check("full_after_16", 32'(rob_full_o), 1);
        check("empty_after_16", 32'(rob_empty_o), 0);
        rinstr_i = {1'b1, 1'b1, 6'd60, 1'b0, 16'h0000};
        tick();
        rinstr_i = '0;
        check("full_after_17th", 32'(rob_full_o), 1);
        check("tag_after_17th", 32'(alloc_tag_o), 0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("empty_after_reset", 32'(rob_empty_o), 1);

        alloc(6'd33, 1'b1, 6'd5, 1'b1, 1'b0, 4'd0, 1'b1);
        alloc(6'd34, 1'b1, 6'd6, 1'b1, 1'b0, 4'd1, 1'b1);
        alloc(6'd35, 1'b1, 6'd7, 1'b1, 1'b0, 4'd2, 1'b1);
        cmpl(4'd2);
        check("no_commit_out_of_order", 32'(p_commit_o[7]), 0);
        cmpl(4'd0);
        check("first_commit_latency", 32'(p_commit_o), 32'({1'b1, 6'd33, 1'b1}));
        cmpl(4'd1);
        repeat (3) tick();
        check("empty_after_drain", 32'(rob_empty_o), 1);

        alloc(6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 4'd3, 1'b1);
        check("br_pending_set", 32'(branch_pending_o), 1);
        alloc(6'd44, 1'b1, 6'd14, 1'b1, 1'b0, 4'd4, 1'b0);
        alloc(6'd45, 1'b1, 6'd15, 1'b1, 1'b0, 4'd5, 1'b0);
        alloc(6'd46, 1'b1, 6'd16, 1'b1, 1'b0, 4'd6, 1'b0);
        cmpl0_valid_i = 1'b1; cmpl0_tag_i = 4'd4;
        cmpl1_valid_i = 1'b1; cmpl1_tag_i = 4'd5;
        tick();
        cmpl1_valid_i = 1'b0;
        cmpl(4'd6);
        cmpl(4'd3);
        check("branch_cmpl_ignored", 32'(p_commit_o[7]), 0);
        br_result_i = 2'b10;
        tick();
        br_result_i = 2'b00;
        check("flush_tail", 32'(alloc_tag_o), 4);
        check("flush_br_pending", 32'(branch_pending_o), 0);
        check("flush_not_empty", 32'(rob_empty_o), 0);
        repeat (3) tick();
        check("flush_empty", 32'(rob_empty_o), 1);
        alloc(6'd40, 1'b1, 6'd8, 1'b1, 1'b0, 4'd4, 1'b1);
        cmpl(4'd4);
        repeat (2) tick();

        alloc(6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 4'd5, 1'b1);
        alloc(6'd20, 1'b1, 6'd1, 1'b1, 1'b0, 4'd6, 1'b1);
        alloc(6'd21, 1'b1, 6'd2, 1'b1, 1'b0, 4'd7, 1'b1);
        alloc(6'd22, 1'b1, 6'd3, 1'b1, 1'b0, 4'd8, 1'b1);
        br_result_i = 2'b11;
        tick();
        br_result_i = 2'b00;
        check("hit_tail", 32'(alloc_tag_o), 9);
        check("hit_br_pending", 32'(branch_pending_o), 0);
        check("hit_branch_commit", 32'(p_commit_o), 32'({1'b1, 6'd0, 1'b1}));
        cmpl0_valid_i = 1'b1; cmpl0_tag_i = 4'd6;
        cmpl1_valid_i = 1'b1; cmpl1_tag_i = 4'd7;
        tick();
        cmpl1_valid_i = 1'b0;
        cmpl(4'd8);
        repeat (3) tick();
        check("hit_empty", 32'(rob_empty_o), 1);

        alloc(6'd30, 1'b1, 6'd0, 1'b1, 1'b0, 4'd9, 1'b1);
        alloc(6'd31, 1'b0, 6'd9, 1'b1, 1'b0, 4'd10, 1'b1);
        alloc(6'd32, 1'b1, 6'd12, 1'b0, 1'b0, 4'd11, 1'b1);
        cmpl0_valid_i = 1'b1; cmpl0_tag_i = 4'd9;
        cmpl1_valid_i = 1'b1; cmpl1_tag_i = 4'd10;
        tick();
        cmpl0_tag_i = 4'd11;
        cmpl1_tag_i = 4'd11;
        tick();
        cmpl0_valid_i = 1'b0;
        cmpl1_valid_i = 1'b0;
        repeat (4) tick();

        for (int k = 0; k < 40; k++) begin
            cmpl0_valid_i = (k > 0);
            cmpl0_tag_i   = 4'((11 + k) % 16);
            alloc(6'(k + 1), 1'b1, 6'(k), 1'b1, 1'b0, 4'((12 + k) % 16), 1'b1);
        end
        cmpl(4'd3);
        repeat (3) tick();
        check("wrap_empty", 32'(rob_empty_o), 1);
        check("wrap_tail", 32'(alloc_tag_o), 4);

        alloc(6'd50, 1'b1, 6'd20, 1'b1, 1'b0, 4'd4, 1'b0);
        alloc(6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 4'd5, 1'b0);
        cmpl(4'd4);
        rst_ni = 1'b0;
        #1;
        check("commit_on_reset", 32'(p_commit_o), 0);
        tick();
        rst_ni = 1'b1;
        check("midrst_empty", 32'(rob_empty_o), 1);
        check("midrst_p_commit", 32'(p_commit_o), 0);
        check("midrst_alloc_tag", 32'(alloc_tag_o), 0);
        check("midrst_br_pending", 32'(branch_pending_o), 0);
        repeat (2) tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
